// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_pkg
//  Description : Shared state encoding and counter-width helper for the
//                parallel-in/serial-out serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_serializer_pkg;

  // One-hot state encoding, same style as the downstream sequence detector.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_SHIFT = 2'b10
  } ser_state_t;

  // Bits needed to count 0..n-1. Never less than one bit, so that a
  // two-bit word still gets a usable counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ser_hold_buf
//  Description : Single-entry holding buffer for the next word while the
//                shifter is still busy with the current one.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // Capture on write; a read empties the entry. The serializer never
  // writes and reads on the same edge, but a write is allowed to win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (write) begin
      r_data <= wdata;
      r_full <= 1'b1;
    end else if (read) begin
      r_full <= 1'b0;
    end
  end

  assign rdata = r_data;
  assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in/serial-out stage with valid/ready load and a
//                one-word holding buffer for gapless streaming. dout is
//                decoded from registered state only.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int             CW     = clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_shifted;
  logic             w_cur_bit;
  logic             w_transfer;
  logic             w_last;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .write (w_hold_wr),
    .read  (w_hold_rd),
    .wdata (data_in),
    .rdata (w_hold_data),
    .full  (w_hold_full)
  );

  // Bit order: the outgoing bit sits at one end and the register shifts
  // toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_cur_bit = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_cur_bit = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign load_ready = ~w_hold_full;
  assign w_transfer = load_valid & ~w_hold_full;
  assign w_last     = (r_cnt == C_LAST);

  // State, shifter and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: load, shift, refill from buffer or bypass at the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_hold_wr   = 1'b0;
    w_hold_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_transfer) begin
          w_shift_nxt = data_in;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + C_ONE;
          w_hold_wr   = w_transfer;
        end else if (w_hold_full) begin
          w_shift_nxt = w_hold_data;
          w_cnt_nxt   = '0;
          w_hold_rd   = 1'b1;
        end else if (w_transfer) begin
          w_shift_nxt = data_in;
          w_cnt_nxt   = '0;
        end else begin
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dout_valid = (r_state == ST_SHIFT);
  assign dout       = dout_valid & w_cur_bit;
  assign busy       = dout_valid | w_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench. An 8-bit MSB-first and a 4-bit
//                LSB-first serializer are run against a bit-queue model:
//                every accepted word appends its bits, one bit leaves per
//                clock, and the holding buffer is full whenever more than
//                one word's worth of bits is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data8 = '0;
  logic       lv8 = 1'b0;
  logic [3:0] data4 = '0;
  logic       lv4 = 1'b0;

  logic ready8, dout8, dv8, busy8;
  logic ready4, dout4, dv4, busy4;

  int tests = 0;
  int fails = 0;

  bit q8[$];
  bit q4[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data8),
    .load_valid (lv8),
    .load_ready (ready8),
    .dout       (dout8),
    .dout_valid (dv8),
    .busy       (busy8)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data4),
    .load_valid (lv4),
    .load_ready (ready4),
    .dout       (dout4),
    .dout_valid (dv4),
    .busy       (busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on each edge the bit on display is consumed, then an accepted
  // word appends its bits in transmit order.
  initial begin
    bit rdy;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q8.delete();
        q4.delete();
      end else begin
        rdy = (q8.size() <= 8);
        if (q8.size() > 0) void'(q8.pop_front());
        if (lv8 && rdy) for (int b = 7; b >= 0; b--) q8.push_back(data8[b]);
        rdy = (q4.size() <= 4);
        if (q4.size() > 0) void'(q4.pop_front());
        if (lv4 && rdy) for (int b = 0; b < 4; b++) q4.push_back(data4[b]);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("dout8",  {31'd0, dout8},  {31'd0, (q8.size() > 0) ? q8[0] : 1'b0});
        chk("dv8",    {31'd0, dv8},    {31'd0, q8.size() > 0});
        chk("busy8",  {31'd0, busy8},  {31'd0, q8.size() > 0});
        chk("ready8", {31'd0, ready8}, {31'd0, q8.size() <= 8});
        chk("dout4",  {31'd0, dout4},  {31'd0, (q4.size() > 0) ? q4[0] : 1'b0});
        chk("dv4",    {31'd0, dv4},    {31'd0, q4.size() > 0});
        chk("busy4",  {31'd0, busy4},  {31'd0, q4.size() > 0});
        chk("ready4", {31'd0, ready4}, {31'd0, q4.size() <= 4});
      end
    end
  end

  initial begin
    logic [15:0] cap;
    logic [3:0]  cap4;

    // Reset state.
    #3;
    chk("rst_dout",  {31'd0, dout8},  32'd0);
    chk("rst_dv",    {31'd0, dv8},    32'd0);
    chk("rst_busy",  {31'd0, busy8},  32'd0);
    chk("rst_ready", {31'd0, ready8}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word B2, MSB first: accepted at edge 0, bits in cycles 1..8.
    @(negedge clk);
    data8 = 8'hB2; lv8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      cap[7-i] = dout8;
      chk("single_ready", {31'd0, ready8}, 32'd1);
      @(negedge clk);
    end
    chk("single_bits", {24'd0, cap[7:0]}, 32'h0000_00B2);
    chk("single_end_dv", {31'd0, dv8}, 32'd0);

    // Back-to-back B2 then 5A through the holding buffer.
    @(negedge clk);
    data8 = 8'hB2; lv8 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      cap[15-i] = dout8;
      chk("b2b_dv", {31'd0, dv8}, 32'd1);
      if (i >= 1 && i <= 7) chk("b2b_ready_low", {31'd0, ready8}, 32'd0);
      if (i == 0) data8 = 8'h5A;
      if (i == 1) lv8 = 1'b0;
      @(negedge clk);
    end
    chk("b2b_bits", {16'd0, cap}, 32'h0000_B25A);
    chk("b2b_end_dv", {31'd0, dv8}, 32'd0);

    // Bypass: FF offered only during the last bit of B2.
    @(negedge clk);
    data8 = 8'hB2; lv8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap[15-i] = dout8;
      chk("byp_dv", {31'd0, dv8}, 32'd1);
      chk("byp_ready", {31'd0, ready8}, 32'd1);
      if (i == 7) begin data8 = 8'hFF; lv8 = 1'b1; end
      if (i == 8) lv8 = 1'b0;
      @(negedge clk);
    end
    chk("byp_bits", {16'd0, cap}, 32'h0000_B2FF);

    // LSB-first, 4-bit word 0001 -> 1,0,0,0.
    @(negedge clk);
    data4 = 4'b0001; lv4 = 1'b1;
    @(negedge clk);
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap4[3-i] = dout4;
      @(negedge clk);
    end
    chk("lsb4_bits", {28'd0, cap4}, 32'h0000_0008);

    // Async reset in the middle of a word (during bit 4).
    data8 = 8'hAA; lv8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",  {31'd0, dout8},  32'd0);
    chk("arst_dv",    {31'd0, dv8},    32'd0);
    chk("arst_busy",  {31'd0, busy8},  32'd0);
    chk("arst_ready", {31'd0, ready8}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data8 = 8'hC3; lv8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap[7-i] = dout8;
      @(negedge clk);
    end
    chk("arst_c3_bits", {24'd0, cap[7:0]}, 32'h0000_00C3);

    // Randomized traffic on both instances with varying offer density.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens  = (i / 500) % 3;
      lv8   = ($urandom_range(0, 3) < (dens + 1));
      lv4   = ($urandom_range(0, 3) < (3 - dens));
      data8 = 8'($urandom);
      data4 = 4'($urandom);
      @(negedge clk);
    end
    lv8 = 1'b0;
    lv4 = 1'b0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the bit-serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on dout, which drives the detector's din.
- A one-entry holding buffer lets consecutive words stream with no idle bit between them.
- dout changes only on the rising edge of clk, so it is stable at the falling edge where the detector samples.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word offered by the producer.
load_valid  input  1  producer has a word on data_in.
load_ready  output  1  block can accept a word this cycle.
dout  output  1  serial bit to the detector's din.
dout_valid  output  1  dout carries a data bit this cycle.
busy  output  1  shifter or holding buffer occupied.

Behaviour:
- Reset (asynchronous, active-low): takes effect immediately, independent of clk, including mid-word.
  - state=IDLE, shift register=0, bit counter=0, holding buffer empty.
  - Outputs: dout=0, dout_valid=0, busy=0, load_ready=1.
  - Any partially sent or held word is discarded.
- Handshake: a transfer occurs on a rising edge where load_valid=1 and load_ready=1.
  - load_ready = NOT hold_full, decoded from registered state only; there is no combinational path from load_valid.
  - data_in is ignored when no transfer occurs.
- States: IDLE, SHIFT. Bit counter cnt, width clog2(WIDTH), counts 0..WIDTH-1.
- IDLE:
  - On transfer, data_in loads straight into the shifter, cnt=0, next state SHIFT.
  - Latency: first bit appears on dout in the cycle after the accepting edge.
  - dout=0 and dout_valid=0 while in IDLE.
- SHIFT:
  - dout = current bit of the shifter (MSB or LSB per MSB_FIRST); dout_valid=1.
  - Each edge, the shifter shifts by one and cnt increments.
  - Transfer when cnt<WIDTH-1: word goes to the holding buffer; hold_full=1.
  - At cnt=WIDTH-1 (last bit), the next edge does one of:
    - hold_full=1: buffer moves into the shifter, cnt=0, hold_full=0. A transfer on that same edge is impossible, since load_ready=0.
    - hold_full=0 and a transfer occurs: data_in bypasses into the shifter, cnt=0, buffer stays empty.
    - otherwise: go to IDLE; dout and dout_valid clear.
  - Streaming is gapless: dout_valid stays 1 across word boundaries whenever the next word is available.
- busy = (state==SHIFT) OR hold_full.
- There is no abort input; only rst_n clears an in-flight word.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SHIFT), one-hot, matching the detector's encoding style;
  - the counter-width function clog2.
- One sub-module is natural: ser_hold_buf, the single-entry buffer.
  - Ports: clk, rst_n, write, read, data in/out, full.
- Shifter, counter and FSM stay in the top module.

Test Plan:
- Reset then single word 8'hB2 (MSB_FIRST=1) accepted at edge 0 -> dout = 1,0,1,1,0,0,1,0 in cycles 1..8, dout_valid=1 in cycles 1..8 and 0 in cycle 9; busy matches dout_valid; load_ready stays 1.
- Back-to-back 8'hB2 then 8'h5A with load_valid held high -> second word accepted at edge 1 into the buffer; load_ready=0 in cycles 2..8; 16 contiguous valid bits 10110010_01011010; dout_valid never drops.
- Bypass: second word 8'hFF offered only in cycle 8 (last bit of the first word) -> accepted; cycles 9..16 dout=1 with dout_valid continuous; buffer never fills.
- MSB_FIRST=0, WIDTH=4, word 4'b0001 -> dout = 1,0,0,0.
- Async reset asserted between edges mid-word (bit 4) -> dout, dout_valid and busy go to 0 before the next edge; load_ready=1. After release, a new word 8'hC3 serializes from its first bit with no remnant of the aborted word.
- Detector integration: word 8'h66 fed through to the detector -> flag pulses as for serial input 0,1,1,0,0,1,1,0 applied directly to din.
